// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions for the two-master arbiter: transfer encodings,
// data-phase owner encoding and the owner-to-grant helper.
package ahbl_pkg;

    localparam int HSIZE_W = 3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Owner encoding doubles as the one-hot grant vector (bit0 = M0).
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_e;

    function automatic logic [1:0] owner_onehot(input owner_e o);
        return o;
    endfunction

endpackage

// File: rtl/ahbl_arb_hold.sv
// One-deep capture register for a master's address phase that lost arbitration
// or arrived during a wait state; pend marks it for replay.
module ahbl_arb_hold
    import ahbl_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               capture,
    input  logic               clear,
    input  logic [AW-1:0]      haddr,
    input  logic [1:0]         htrans,
    input  logic               hwrite,
    input  logic [HSIZE_W-1:0] hsize,
    output logic               pend,
    output logic [AW-1:0]      hold_addr,
    output logic [1:0]         hold_trans,
    output logic               hold_write,
    output logic [HSIZE_W-1:0] hold_size
);

    logic               pend_r;
    logic [AW-1:0]      addr_r;
    logic [1:0]         trans_r;
    logic               write_r;
    logic [HSIZE_W-1:0] size_r;

    // Capture the address phase and set pend; clear pend once replayed.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pend_r  <= 1'b0;
            addr_r  <= {AW{1'b0}};
            trans_r <= HTRANS_IDLE;
            write_r <= 1'b0;
            size_r  <= {HSIZE_W{1'b0}};
        end else if (capture) begin
            pend_r  <= 1'b1;
            addr_r  <= haddr;
            trans_r <= htrans;
            write_r <= hwrite;
            size_r  <= hsize;
        end else if (clear) begin
            pend_r  <= 1'b0;
        end else begin
            pend_r  <= pend_r;
        end
    end

    assign pend       = pend_r;
    assign hold_addr  = addr_r;
    assign hold_trans = trans_r;
    assign hold_write = write_r;
    assign hold_size  = size_r;

endmodule

// File: rtl/ahbl_master_arbiter.sv
// Two-master AHB-Lite arbiter with zero-latency pass-through and replay of
// losing address phases. Define AHBL_ARB_RR_EN for round-robin, else fixed priority.
module ahbl_master_arbiter
    import ahbl_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int HIGH_PRIO = 0
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [AW-1:0]      M0_HADDR,
    input  logic [1:0]         M0_HTRANS,
    input  logic               M0_HWRITE,
    input  logic [HSIZE_W-1:0] M0_HSIZE,
    input  logic [DW-1:0]      M0_HWDATA,
    output logic               M0_HREADY,
    output logic [DW-1:0]      M0_HRDATA,
    input  logic [AW-1:0]      M1_HADDR,
    input  logic [1:0]         M1_HTRANS,
    input  logic               M1_HWRITE,
    input  logic [HSIZE_W-1:0] M1_HSIZE,
    input  logic [DW-1:0]      M1_HWDATA,
    output logic               M1_HREADY,
    output logic [DW-1:0]      M1_HRDATA,
    output logic [AW-1:0]      S_HADDR,
    output logic [1:0]         S_HTRANS,
    output logic               S_HWRITE,
    output logic [HSIZE_W-1:0] S_HSIZE,
    output logic [DW-1:0]      S_HWDATA,
    input  logic               S_HREADY,
    input  logic [DW-1:0]      S_HRDATA,
    output logic [1:0]         GRANT
);

    owner_e             downer_r, downer_s, win_s;
    logic               m0_rdy_s, m1_rdy_s;
    logic               acc0_s, acc1_s, cand0_s, cand1_s;
    logic               cap0_s, cap1_s, clr0_s, clr1_s;
    logic               pend0_s, pend1_s;
    logic [AW-1:0]      h0_addr_s, h1_addr_s;
    logic [1:0]         h0_trans_s, h1_trans_s;
    logic               h0_write_s, h1_write_s;
    logic [HSIZE_W-1:0] h0_size_s, h1_size_s;

`ifdef AHBL_ARB_RR_EN
    logic rr_last_r, rr_last_s;
`endif

    // Per-master ready: data-phase owner follows the slave, a pending master stalls.
    always_comb begin
        m0_rdy_s = 1'b1;
        m1_rdy_s = 1'b1;
        if (downer_r == OWN_M0) m0_rdy_s = S_HREADY;
        else if (pend0_s)       m0_rdy_s = 1'b0;
        else                    m0_rdy_s = 1'b1;
        if (downer_r == OWN_M1) m1_rdy_s = S_HREADY;
        else if (pend1_s)       m1_rdy_s = 1'b0;
        else                    m1_rdy_s = 1'b1;
    end

    assign acc0_s  = M0_HTRANS[1] & m0_rdy_s;
    assign acc1_s  = M1_HTRANS[1] & m1_rdy_s;
    assign cand0_s = pend0_s | acc0_s;
    assign cand1_s = pend1_s | acc1_s;

    // Winner selection; nobody wins during a wait state or reset.
    always_comb begin
        win_s = OWN_NONE;
        if (HRESET || !S_HREADY) begin
            win_s = OWN_NONE;
        end else if (cand0_s && cand1_s) begin
`ifdef AHBL_ARB_RR_EN
            win_s = rr_last_r ? OWN_M0 : OWN_M1;
`else
            win_s = (HIGH_PRIO == 1) ? OWN_M1 : OWN_M0;
`endif
        end else if (cand0_s) begin
            win_s = OWN_M0;
        end else if (cand1_s) begin
            win_s = OWN_M1;
        end else begin
            win_s = OWN_NONE;
        end
    end

    assign cap0_s = acc0_s & (win_s != OWN_M0);
    assign cap1_s = acc1_s & (win_s != OWN_M1);
    assign clr0_s = pend0_s & (win_s == OWN_M0);
    assign clr1_s = pend1_s & (win_s == OWN_M1);

    ahbl_arb_hold #(.AW(AW)) u_hold0 (
        .HCLK(HCLK), .HRESET(HRESET), .capture(cap0_s), .clear(clr0_s),
        .haddr(M0_HADDR), .htrans(M0_HTRANS), .hwrite(M0_HWRITE), .hsize(M0_HSIZE),
        .pend(pend0_s), .hold_addr(h0_addr_s), .hold_trans(h0_trans_s),
        .hold_write(h0_write_s), .hold_size(h0_size_s)
    );

    ahbl_arb_hold #(.AW(AW)) u_hold1 (
        .HCLK(HCLK), .HRESET(HRESET), .capture(cap1_s), .clear(clr1_s),
        .haddr(M1_HADDR), .htrans(M1_HTRANS), .hwrite(M1_HWRITE), .hsize(M1_HSIZE),
        .pend(pend1_s), .hold_addr(h1_addr_s), .hold_trans(h1_trans_s),
        .hold_write(h1_write_s), .hold_size(h1_size_s)
    );

    // Next data-phase owner (and round-robin pointer) only move on a ready cycle.
    always_comb begin
        downer_s = downer_r;
        if (S_HREADY) downer_s = win_s;
        else          downer_s = downer_r;
`ifdef AHBL_ARB_RR_EN
        rr_last_s = rr_last_r;
        if (S_HREADY && (win_s != OWN_NONE)) rr_last_s = (win_s == OWN_M1);
        else                                 rr_last_s = rr_last_r;
`endif
    end

    // Arbiter state register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            downer_r <= OWN_NONE;
`ifdef AHBL_ARB_RR_EN
            rr_last_r <= 1'b1;
`endif
        end else begin
            downer_r <= downer_s;
`ifdef AHBL_ARB_RR_EN
            rr_last_r <= rr_last_s;
`endif
        end
    end

    // Address-phase mux: replay from hold if pending, else pass live inputs through.
    always_comb begin
        S_HADDR  = {AW{1'b0}};
        S_HTRANS = HTRANS_IDLE;
        S_HWRITE = 1'b0;
        S_HSIZE  = {HSIZE_W{1'b0}};
        case (win_s)
            OWN_M0: begin
                if (pend0_s) begin
                    S_HADDR = h0_addr_s;  S_HTRANS = h0_trans_s;
                    S_HWRITE = h0_write_s; S_HSIZE = h0_size_s;
                end else begin
                    S_HADDR = M0_HADDR;   S_HTRANS = M0_HTRANS;
                    S_HWRITE = M0_HWRITE; S_HSIZE = M0_HSIZE;
                end
            end
            OWN_M1: begin
                if (pend1_s) begin
                    S_HADDR = h1_addr_s;  S_HTRANS = h1_trans_s;
                    S_HWRITE = h1_write_s; S_HSIZE = h1_size_s;
                end else begin
                    S_HADDR = M1_HADDR;   S_HTRANS = M1_HTRANS;
                    S_HWRITE = M1_HWRITE; S_HSIZE = M1_HSIZE;
                end
            end
            default: begin
                S_HTRANS = HTRANS_IDLE;
            end
        endcase
    end

    // Write data follows the data-phase owner.
    always_comb begin
        S_HWDATA = {DW{1'b0}};
        case (downer_r)
            OWN_M0:  S_HWDATA = M0_HWDATA;
            OWN_M1:  S_HWDATA = M1_HWDATA;
            default: S_HWDATA = {DW{1'b0}};
        endcase
    end

    assign GRANT     = owner_onehot(win_s);
    assign M0_HREADY = m0_rdy_s;
    assign M1_HREADY = m1_rdy_s;
    assign M0_HRDATA = S_HRDATA;
    assign M1_HRDATA = S_HRDATA;

endmodule

// File: tb/tb_ahbl_master_arbiter.sv
// Directed self-checking bench for ahbl_master_arbiter (fixed priority by default,
// round-robin expectations when AHBL_ARB_RR_EN is defined).
module tb_ahbl_master_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA, M0_HRDATA, M1_HRDATA;
    logic [1:0]  M0_HTRANS, M1_HTRANS;
    logic        M0_HWRITE, M1_HWRITE, M0_HREADY, M1_HREADY;
    logic [2:0]  M0_HSIZE, M1_HSIZE;
    logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
    logic [1:0]  S_HTRANS, GRANT;
    logic        S_HWRITE, S_HREADY;
    logic [2:0]  S_HSIZE;

    int checks   = 0;
    int failures = 0;
    logic [1:0] exp_g [4];

    always #5 HCLK = ~HCLK;

    ahbl_master_arbiter #(.AW(32), .DW(32), .HIGH_PRIO(0)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
        .M0_HSIZE(M0_HSIZE), .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY), .M0_HRDATA(M0_HRDATA),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
        .M1_HSIZE(M1_HSIZE), .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY), .M1_HRDATA(M1_HRDATA),
        .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE),
        .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY), .S_HRDATA(S_HRDATA), .GRANT(GRANT)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic sample();
        @(negedge HCLK);
    endtask

    task automatic drive_m0(input logic [1:0] tr, input logic [31:0] a, input logic w);
        M0_HTRANS = tr; M0_HADDR = a; M0_HWRITE = w; M0_HSIZE = 3'd2;
    endtask

    task automatic drive_m1(input logic [1:0] tr, input logic [31:0] a, input logic w);
        M1_HTRANS = tr; M1_HADDR = a; M1_HWRITE = w; M1_HSIZE = 3'd2;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef AHBL_ARB_RR_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        HRESET = 1'b1; S_HREADY = 1'b1; S_HRDATA = 32'h0;
        M0_HWDATA = 32'h1111_1111; M1_HWDATA = 32'hDEAD_BEEF;
        drive_m0(2'b00, 32'h0, 1'b0);
        drive_m1(2'b00, 32'h0, 1'b0);
        tick(); tick();
        sample();
        check_eq("rst_m0_rdy", M0_HREADY, 1'b1);
        check_eq("rst_m1_rdy", M1_HREADY, 1'b1);
        check_eq("rst_trans", S_HTRANS, 2'b00);
        check_eq("rst_addr", S_HADDR, 32'h0);
        check_eq("rst_grant", GRANT, 2'b00);
        tick();
        HRESET = 1'b0;

        // Test 1: lone M0 read, zero-latency pass-through
        drive_m0(2'b10, 32'h4000_0000, 1'b0);
        sample();
        check_eq("t1_trans", S_HTRANS, 2'b10);
        check_eq("t1_addr", S_HADDR, 32'h4000_0000);
        check_eq("t1_grant", GRANT, 2'b01);
        check_eq("t1_m1_rdy_a", M1_HREADY, 1'b1);
        tick();
        drive_m0(2'b00, 32'h0, 1'b0);
        S_HREADY = 1'b0; S_HRDATA = 32'h1234_5678;
        sample();
        check_eq("t1_m0_rdy_wait", M0_HREADY, 1'b0);
        check_eq("t1_m1_rdy_b", M1_HREADY, 1'b1);
        check_eq("t1_rdata", M0_HRDATA, 32'h1234_5678);
        tick();
        S_HREADY = 1'b1;
        sample();
        check_eq("t1_m0_rdy_done", M0_HREADY, 1'b1);
        tick();

        // Test 2: simultaneous requests, M1 replayed from hold
        drive_m0(2'b10, 32'h4100_0004, 1'b0);
        drive_m1(2'b10, 32'h4200_0008, 1'b0);
        sample();
        check_eq("t2_c0_addr", S_HADDR, 32'h4100_0004);
        check_eq("t2_c0_grant", GRANT, 2'b01);
        tick();
        drive_m0(2'b00, 32'h0, 1'b0);
        sample();
        check_eq("t2_c1_m1_rdy", M1_HREADY, 1'b0);
        check_eq("t2_c1_addr", S_HADDR, 32'h4200_0008);
        check_eq("t2_c1_trans", S_HTRANS, 2'b10);
        check_eq("t2_c1_grant", GRANT, 2'b10);
        tick();
        drive_m1(2'b00, 32'h0, 1'b0);
        sample();
        check_eq("t2_c2_m1_rdy", M1_HREADY, 1'b1);
        check_eq("t2_c2_trans", S_HTRANS, 2'b00);
        tick();

        // Test 3: wait states in M0 data phase while M1 issues
        drive_m0(2'b10, 32'h4000_0100, 1'b0);
        tick();
        drive_m0(2'b00, 32'h0, 1'b0);
        drive_m1(2'b10, 32'h4300_0000, 1'b0);
        S_HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check_eq("t3_wait_trans", S_HTRANS, 2'b00);
            check_eq("t3_wait_grant", GRANT, 2'b00);
            check_eq("t3_wait_m0_rdy", M0_HREADY, 1'b0);
            tick();
        end
        S_HREADY = 1'b1;
        sample();
        check_eq("t3_m1_rdy_pend", M1_HREADY, 1'b0);
        check_eq("t3_addr", S_HADDR, 32'h4300_0000);
        check_eq("t3_trans", S_HTRANS, 2'b10);
        check_eq("t3_grant", GRANT, 2'b10);
        tick();
        drive_m1(2'b00, 32'h0, 1'b0);
        tick();

        // Test 4: M1 write replayed with its held write data
        drive_m0(2'b10, 32'h4000_0200, 1'b0);
        drive_m1(2'b10, 32'h4400_0010, 1'b1);
        sample();
        check_eq("t4_c0_grant", GRANT, 2'b01);
        check_eq("t4_c0_write", S_HWRITE, 1'b0);
        tick();
        drive_m0(2'b00, 32'h0, 1'b0);
        sample();
        check_eq("t4_c1_wdata_m0", S_HWDATA, 32'h1111_1111);
        check_eq("t4_c1_write", S_HWRITE, 1'b1);
        check_eq("t4_c1_addr", S_HADDR, 32'h4400_0010);
        check_eq("t4_c1_size", S_HSIZE, 3'd2);
        tick();
        drive_m1(2'b00, 32'h0, 1'b0);
        sample();
        check_eq("t4_c2_wdata_m1", S_HWDATA, 32'hDEAD_BEEF);
        tick();

        // Test 5: both masters requesting continuously
        drive_m0(2'b10, 32'h4000_0000, 1'b0);
        drive_m1(2'b10, 32'h4200_0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            sample();
            check_eq("t5_grant", GRANT, exp_g[i]);
            tick();
        end
        drive_m0(2'b00, 32'h0, 1'b0);
        drive_m1(2'b00, 32'h0, 1'b0);
        tick(); tick(); tick();

        // Test 6: reset with pend[1]=1 and downer=M0
        drive_m0(2'b10, 32'h4000_0300, 1'b0);
        tick();
        drive_m0(2'b00, 32'h0, 1'b0);
        drive_m1(2'b10, 32'h4300_0040, 1'b0);
        S_HREADY = 1'b0;
        tick();
        drive_m1(2'b00, 32'h0, 1'b0);
        sample();
        check_eq("t6_pre_m1_rdy", M1_HREADY, 1'b0);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        sample();
        check_eq("t6_m0_rdy", M0_HREADY, 1'b1);
        check_eq("t6_m1_rdy", M1_HREADY, 1'b1);
        S_HREADY = 1'b1;
        #1;
        check_eq("t6_trans", S_HTRANS, 2'b00);
        check_eq("t6_grant", GRANT, 2'b00);
        tick();
        drive_m0(2'b10, 32'h4000_0400, 1'b0);
        drive_m1(2'b10, 32'h4200_0400, 1'b0);
        sample();
        check_eq("t6_post_grant", GRANT, 2'b01);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
